// File: rtl/dma_wr_engine.sv
// Channel write-side DMA master: drains the data FIFO into bus write bursts
// of at most MAX_BURST beats and reports completion or error per command.
module dma_wr_engine #(
    parameter int unsigned DATA_WD   = 32,
    parameter int unsigned ADDR_WD   = 32,
    parameter int unsigned LEN_WD    = 16,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [ADDR_WD-1:0] cmd_addr_i,
    input  logic [LEN_WD-1:0]  cmd_len_i,
    input  logic               fifo_valid_i,
    input  logic [DATA_WD-1:0] fifo_data_i,
    output logic               fifo_ready_o,
    output logic               aw_valid_o,
    input  logic               aw_ready_i,
    output logic [ADDR_WD-1:0] aw_addr_o,
    output logic [7:0]         aw_len_o,
    output logic               w_valid_o,
    input  logic               w_ready_i,
    output logic [DATA_WD-1:0] w_data_o,
    output logic               w_last_o,
    input  logic               b_valid_i,
    output logic               b_ready_o,
    input  logic [1:0]         b_resp_i,
    output logic               done_o,
    output logic               err_o
);

    localparam int unsigned ADDR_LSB = $clog2(DATA_WD / 8);
    // Counter width must hold both a full burst (up to 256) and the remaining length.
    localparam int unsigned CNT_WD   = (LEN_WD > 9) ? LEN_WD : 9;
    localparam logic [ADDR_WD-1:0] ALIGN_MASK = ~ADDR_WD'((64'd1 << ADDR_LSB) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_WD-1:0]  addr_q, addr_d;
    logic [LEN_WD-1:0]   rem_q, rem_d;
    logic [CNT_WD-1:0]   beat_q, beat_d;
    logic                err_q, err_d;
    logic [CNT_WD-1:0]   burst_c;
    logic                last_c;

    // Current burst size; rem_q only changes in B, so this is stable across AW and W.
    assign burst_c = (CNT_WD'(rem_q) >= CNT_WD'(MAX_BURST)) ? CNT_WD'(MAX_BURST)
                                                            : CNT_WD'(rem_q);
    assign last_c  = (beat_q == (burst_c - CNT_WD'(1)));
    assign err_o   = err_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        beat_d       = beat_q;
        err_d        = err_q;
        cmd_ready_o  = 1'b0;
        aw_valid_o   = 1'b0;
        aw_addr_o    = '0;
        aw_len_o     = '0;
        w_valid_o    = 1'b0;
        w_data_o     = '0;
        w_last_o     = 1'b0;
        fifo_ready_o = 1'b0;
        b_ready_o    = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i & ALIGN_MASK;
                    rem_d   = cmd_len_i;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = (cmd_len_i == '0) ? S_DONE : S_AW;
                end
            end
            S_AW: begin
                aw_valid_o = 1'b1;
                aw_addr_o  = addr_q;
                aw_len_o   = 8'(burst_c - CNT_WD'(1));
                if (aw_ready_i) begin
                    beat_d  = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                // Zero-latency pass-through between FIFO and write channel.
                w_valid_o    = fifo_valid_i;
                fifo_ready_o = w_ready_i;
                w_data_o     = fifo_data_i;
                w_last_o     = last_c;
                if (fifo_valid_i && w_ready_i) begin
                    beat_d = beat_q + CNT_WD'(1);
                    if (last_c) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    if (b_resp_i != 2'd0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rem_d   = rem_q - LEN_WD'(burst_c);
                        addr_d  = addr_q + (ADDR_WD'(burst_c) << ADDR_LSB);
                        state_d = (rem_q == LEN_WD'(burst_c)) ? S_DONE : S_AW;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_wr_engine.sv
// Scoreboard bench for dma_wr_engine: a burst-splitting reference model fills
// expected queues; a negedge monitor pops and compares every handshake.
module tb_dma_wr_engine;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 16;
    localparam int unsigned MB = 16;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_addr_i;
    logic [LW-1:0] cmd_len_i;
    logic          fifo_valid_i;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_ready_o;
    logic          aw_valid_o;
    logic          aw_ready_i;
    logic [AW-1:0] aw_addr_o;
    logic [7:0]    aw_len_o;
    logic          w_valid_o;
    logic          w_ready_i;
    logic [DW-1:0] w_data_o;
    logic          w_last_o;
    logic          b_valid_i;
    logic          b_ready_o;
    logic [1:0]    b_resp_i;
    logic          done_o;
    logic          err_o;

    dma_wr_engine #(.DATA_WD(DW), .ADDR_WD(AW), .LEN_WD(LW), .MAX_BURST(MB)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .fifo_valid_i(fifo_valid_i), .fifo_data_i(fifo_data_i), .fifo_ready_o(fifo_ready_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .w_data_o(w_data_o), .w_last_o(w_last_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic [39:0] exp_aw[$];    // {addr, len}
    logic [32:0] exp_w[$];     // {last, data}
    bit          exp_done[$];  // expected err_o at done
    logic [1:0]  plan[$];      // b responses the bench will return
    logic [31:0] fifo_q[$];    // FIFO contents

    int aw_pct = 100, w_pct = 100, f_pct = 100, b_pct = 100;
    bit stall_mode = 1'b0;
    bit fifo_pop = 1'b0, b_pop = 1'b0;
    int cyc = 0, aw_wait = 0, acc_cyc = 0, done_cyc = 0;
    int n_pop = 0, n_wfire = 0;
    bit prev_aw_stall = 1'b0, prev_done = 1'b0;
    logic [AW-1:0] prev_aw_addr;
    logic [7:0]    prev_aw_len;
    logic [39:0]   e_aw;
    logic [32:0]   e_w;
    bit            e_d;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Input driver: random handshakes applied just after each rising edge.
    always @(posedge clk_i) begin
        cyc++;
        #1;
        if (fifo_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (b_pop && plan.size() > 0) void'(plan.pop_front());
        if (aw_valid_o) aw_wait++; else aw_wait = 0;
        aw_ready_i   = stall_mode ? (aw_wait > 5) : ($urandom_range(0, 99) < aw_pct);
        w_ready_i    = ($urandom_range(0, 99) < w_pct);
        fifo_valid_i = (fifo_q.size() > 0) && ($urandom_range(0, 99) < f_pct);
        fifo_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : $urandom;
        b_valid_i    = ($urandom_range(0, 99) < b_pct);
        b_resp_i     = (plan.size() > 0) ? plan[0] : 2'($urandom);
    end

    // Monitor: compares every handshake against the scoreboard queues.
    always @(negedge clk_i) begin
        fifo_pop = fifo_valid_i && fifo_ready_o;
        b_pop    = b_valid_i && b_ready_o;
        if (!rstn_i) begin
            prev_aw_stall = 1'b0;
            prev_done     = 1'b0;
        end else begin
            if (aw_valid_o && prev_aw_stall) begin
                check("aw_addr_stable", aw_addr_o, prev_aw_addr);
                check("aw_len_stable", aw_len_o, prev_aw_len);
            end
            if (aw_valid_o && aw_ready_i) begin
                if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
                else begin
                    e_aw = exp_aw.pop_front();
                    check("aw_addr", aw_addr_o, e_aw[39:8]);
                    check("aw_len", aw_len_o, e_aw[7:0]);
                end
            end
            prev_aw_stall = aw_valid_o && !aw_ready_i;
            prev_aw_addr  = aw_addr_o;
            prev_aw_len   = aw_len_o;
            if (fifo_pop) n_pop++;
            if (fifo_pop || (w_valid_o && w_ready_i))
                check("pop_vs_wbeat", fifo_pop, w_valid_o && w_ready_i);
            if (w_valid_o && w_ready_i) begin
                n_wfire++;
                if (exp_w.size() == 0) check("w_unexpected", 1, 0);
                else begin
                    e_w = exp_w.pop_front();
                    check("w_data", w_data_o, e_w[31:0]);
                    check("w_last", w_last_o, e_w[32]);
                end
            end
            if (b_pop && plan.size() == 0) check("b_unexpected", 1, 0);
            if (cmd_valid_i && cmd_ready_o) acc_cyc = cyc;
            if (done_o) begin
                check("done_width", prev_done, 0);
                done_cyc = cyc;
                if (exp_done.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    e_d = exp_done.pop_front();
                    check("err_at_done", err_o, e_d);
                end
            end
            prev_done = done_o;
        end
    end

    // Reference model: split the transfer into bursts and fill all queues.
    task automatic model_cmd(input logic [31:0] addr, input int len, input int err_burst,
                             output bit err);
        logic [31:0] a;
        int rem;
        int bi;
        a   = addr - (addr % 4);
        rem = len;
        bi  = 0;
        err = 1'b0;
        while (rem > 0 && !err) begin
            int b;
            b = (rem < MB) ? rem : MB;
            exp_aw.push_back({a, 8'(b - 1)});
            for (int k = 0; k < b; k++) begin
                logic [31:0] d;
                d = $urandom;
                fifo_q.push_back(d);
                exp_w.push_back({(k == b - 1), d});
            end
            if (bi == err_burst) begin
                plan.push_back(2'($urandom_range(1, 3)));
                err = 1'b1;
            end else begin
                plan.push_back(2'd0);
            end
            rem -= b;
            a   += 32'(b * 4);
            bi++;
        end
        exp_done.push_back(err);
    endtask

    task automatic issue_cmd(input logic [31:0] addr, input int len);
        bit got;
        got = 1'b0;
        @(posedge clk_i); #1;
        cmd_addr_i  = addr;
        cmd_len_i   = LW'(len);
        cmd_valid_i = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (cmd_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        check("cmd_accept", got, 1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        cmd_addr_i  = $urandom;
        cmd_len_i   = LW'($urandom);
        @(negedge clk_i);
        check("err_cleared_on_accept", err_o, 0);
    endtask

    task automatic send_cmd(input logic [31:0] addr, input int len, input int err_burst);
        bit err;
        model_cmd(addr, len, err_burst, err);
        issue_cmd(addr, len);
        for (int n = 0; n < 20000; n++) begin
            if (exp_done.size() == 0) break;
            @(negedge clk_i);
        end
        check("done_timeout", exp_done.size(), 0);
        repeat (2) @(negedge clk_i);
        check("aw_left", exp_aw.size(), 0);
        check("w_left", exp_w.size(), 0);
        check("fifo_left", fifo_q.size(), 0);
        check("resp_left", plan.size(), 0);
        check("err_sticky", err_o, err);
        check("pops_eq_beats", n_pop, n_wfire);
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_aw_valid", aw_valid_o, 0);
        check("rst_aw_addr", aw_addr_o, 0);
        check("rst_aw_len", aw_len_o, 0);
        check("rst_w_valid", w_valid_o, 0);
        check("rst_w_data", w_data_o, 0);
        check("rst_w_last", w_last_o, 0);
        check("rst_fifo_ready", fifo_ready_o, 0);
        check("rst_b_ready", b_ready_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
    endtask

    initial begin
        bit err;
        rstn_i       = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_addr_i   = '0;
        cmd_len_i    = '0;
        fifo_valid_i = 1'b0;
        fifo_data_i  = '0;
        aw_ready_i   = 1'b0;
        w_ready_i    = 1'b0;
        b_valid_i    = 1'b0;
        b_resp_i     = 2'd0;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;

        send_cmd(32'h0000_1000, 4, -1);
        send_cmd(32'h0000_2000, 40, -1);

        stall_mode = 1'b1; f_pct = 60; w_pct = 60; b_pct = 50;
        send_cmd(32'h0000_4000, 40, -1);
        stall_mode = 1'b0; f_pct = 100; w_pct = 100; b_pct = 100;

        send_cmd(32'h0000_5000, 32, 1);
        send_cmd(32'h0000_6000, 8, -1);

        send_cmd(32'h0000_7000, 0, -1);
        check("zero_len_done_latency", done_cyc - acc_cyc, 1);
        send_cmd(32'h0000_1003, 4, -1);
        send_cmd(32'hFFFF_FFC0, 40, -1);
        send_cmd(32'h0000_8000, 16, -1);
        send_cmd(32'h0000_8100, 17, -1);

        // Reset while the burst is stalled after 2 of 4 beats.
        model_cmd(32'h0000_3000, 4, -1, err);
        void'(fifo_q.pop_back());
        void'(fifo_q.pop_back());
        issue_cmd(32'h0000_3000, 4);
        for (int n = 0; n < 200; n++) begin
            if (exp_w.size() <= 2) break;
            @(negedge clk_i);
        end
        check("two_beats_before_reset", exp_w.size(), 2);
        @(posedge clk_i); #1;
        rstn_i = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        exp_aw.delete(); exp_w.delete(); exp_done.delete(); plan.delete(); fifo_q.delete();
        n_pop = 0; n_wfire = 0;
        @(negedge clk_i);
        check("cmd_ready_after_reset", cmd_ready_o, 1);
        send_cmd(32'h0000_3000, 4, -1);

        for (int t = 0; t < 25; t++) begin
            aw_pct = $urandom_range(30, 100);
            w_pct  = $urandom_range(30, 100);
            f_pct  = $urandom_range(30, 100);
            b_pct  = $urandom_range(30, 100);
            send_cmd($urandom, $urandom_range(0, 70),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
